// File: rtl/hilo_muldiv_unit_if.sv
// Request/result bundle between the EX-stage control and the HI/LO multiply/divide unit.
interface hilo_muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mthi_we;
  logic             mtlo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi_data;
  logic [WIDTH-1:0] lo_data;

  modport master (
    output start, op, a, b, mthi_we, mtlo_we, wdata,
    input  busy, done, div_by_zero, hi_data, lo_data
  );

  modport slave (
    input  start, op, a, b, mthi_we, mtlo_we, wdata,
    output busy, done, div_by_zero, hi_data, lo_data
  );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Iterative shift-add multiply / restoring divide owning the HI/LO pair.
// Optional MULDIV_EARLY_TERM_EN: multiplies leave CALC once the remaining multiplier bits are zero.
module hilo_muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic               clk,
  input logic               rst_n,
  hilo_muldiv_unit_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_CALC, S_FIX} state_e;

  state_e             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic               dz_q, dz_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;   // |a| for mult; dividend/quotient shifter for div
  logic [WIDTH-1:0]   mplier_q, mplier_d; // |b|: multiplier or divisor
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, done_q, dbz_q;
  logic               done_d, dbz_d;

  logic               sgn;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     shl;
  logic               ge;
  logic [2*WIDTH-1:0] prod;
  logic               calc_last_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_PREP;
      S_PREP:  state_d = (op_q[1] && (mplier_q == '0)) ? S_FIX : S_CALC;
      S_CALC:  if (calc_last_c) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    op_d        = op_q;
    neg_d       = neg_q;
    rneg_d      = rneg_q;
    dz_d        = dz_q;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    rem_d       = rem_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    done_d      = 1'b0;
    dbz_d       = 1'b0;
    sgn         = 1'b0;
    sum         = '0;
    shl         = '0;
    ge          = 1'b0;
    prod        = '0;
    calc_last_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.mthi_we) hi_d = bus.wdata;
        if (bus.mtlo_we) lo_d = bus.wdata;
        if (bus.start) begin
          op_d     = bus.op;
          mcand_d  = bus.a;
          mplier_d = bus.b;
        end
      end
      S_PREP: begin
        sgn    = ~op_q[0];
        neg_d  = sgn & (mcand_q[WIDTH-1] ^ mplier_q[WIDTH-1]);
        rneg_d = sgn & mcand_q[WIDTH-1];
        if (sgn && mcand_q[WIDTH-1])  mcand_d  = -mcand_q;
        if (sgn && mplier_q[WIDTH-1]) mplier_d = -mplier_q;
        dz_d  = op_q[1] && (mplier_q == '0);
        cnt_d = CW'(WIDTH);
        acc_d = '0;
        rem_d = '0;
      end
      S_CALC: begin
        cnt_d       = cnt_q - CW'(1);
        calc_last_c = (cnt_q == CW'(1));
        if (!op_q[1]) begin
          // Add into the upper half, then shift the whole accumulator right.
          sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
          acc_d    = {sum, acc_q[WIDTH-1:1]};
          mplier_d = mplier_q >> 1;
`ifdef MULDIV_EARLY_TERM_EN
          if (mplier_d == '0) calc_last_c = 1'b1;
`endif
        end else begin
          shl     = {rem_q, mcand_q[WIDTH-1]};
          ge      = (shl >= {1'b0, mplier_q});
          rem_d   = WIDTH'(ge ? shl - {1'b0, mplier_q} : shl);
          mcand_d = {mcand_q[WIDTH-2:0], ge};
        end
      end
      S_FIX: begin
        done_d = 1'b1;
        if (dz_q) begin
          dbz_d = 1'b1;
        end else if (!op_q[1]) begin
`ifdef MULDIV_EARLY_TERM_EN
          prod = acc_q >> cnt_q;
`else
          prod = acc_q;
`endif
          if (neg_q) prod = -prod;
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end else begin
          lo_d = neg_q  ? -mcand_q : mcand_q;
          hi_d = rneg_q ? -rem_q   : rem_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      op_q     <= op_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= (state_d != S_IDLE);
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi_data     = hi_q;
  assign bus.lo_data     = lo_q;
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: vector table plus handshake / reset corner sequences.
// Expected latencies follow MULDIV_EARLY_TERM_EN when the bench is built with it.
module tb_hilo_muldiv_unit;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hilo_muldiv_unit_if #(.WIDTH(W)) bus ();
  hilo_muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Expected start-to-done latency in cycles.
  function automatic int exp_lat(input logic [1:0] op, input logic [W-1:0] b);
`ifdef MULDIV_EARLY_TERM_EN
    logic [W-1:0] ub;
    int bl;
    if (!op[1]) begin
      ub = (!op[0] && b[W-1]) ? -b : b;
      bl = 0;
      for (int i = 0; i < int'(W); i++) if (ub[i]) bl = i + 1;
      return 2 + ((bl < 1) ? 1 : bl);
    end
`endif
    if (op[1] && (b == '0)) return 2;
    return int'(W) + 2;
  endfunction

  task automatic launch(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = 32'h5A5A_5A5A;
    bus.b     = 32'hA5A5_A5A5;
  endtask

  task automatic wait_done(input int n0, output int n, output logic to);
    n = n0;
    while (!bus.done && n < 200) begin
      @(negedge clk);
      n++;
    end
    to = !bus.done;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic to;
    int seen;

    vecs[0]  = '{2'b00, 32'hFFFF_FFFB, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[1]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    vecs[3]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[4]  = '{2'b11, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E};
    vecs[5]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[6]  = '{2'b01, 32'd7,         32'd2,         32'h0000_0000, 32'h0000_000E};
    vecs[7]  = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[8]  = '{2'b00, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};
    vecs[9]  = '{2'b10, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'h0000_0002};
    vecs[10] = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF};
    vecs[11] = '{2'b00, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001};
    vecs[12] = '{2'b11, 32'd5,         32'd9,         32'h0000_0005, 32'h0000_0000};

    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    bus.mthi_we = 1'b0; bus.mtlo_we = 1'b0; bus.wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_dbz", bus.div_by_zero, 0);
    chk("rst_hi", bus.hi_data, 0);
    chk("rst_lo", bus.lo_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b);
      chk($sformatf("v%0d_busy_start", i), bus.busy, 1);
      wait_done(0, n, to);
      chk($sformatf("v%0d_timeout", i), to, 0);
      chk($sformatf("v%0d_latency", i), 64'(n), 64'(exp_lat(vecs[i].op, vecs[i].b)));
      chk($sformatf("v%0d_hi", i), bus.hi_data, vecs[i].hi);
      chk($sformatf("v%0d_lo", i), bus.lo_data, vecs[i].lo);
      chk($sformatf("v%0d_dbz", i), bus.div_by_zero, 0);
      chk($sformatf("v%0d_busy_done", i), bus.busy, 0);
      @(negedge clk);
    end

    // Stray start and mthi mid-CALC are dropped.
    launch(2'b01, 32'd6, 32'h8000_0007);
    repeat (10) @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd1; bus.b = 32'd1;
    bus.mthi_we = 1'b1; bus.wdata = 32'h0000_DEAD;
    @(negedge clk);
    bus.start = 1'b0; bus.mthi_we = 1'b0;
    wait_done(11, n, to);
    chk("busy_ign_timeout", to, 0);
    chk("busy_ign_latency", 64'(n), 64'(W + 2));
    chk("busy_ign_hi", bus.hi_data, 32'h0000_0003);
    chk("busy_ign_lo", bus.lo_data, 32'h0000_002A);

    // New start in the done cycle is accepted.
    launch(2'b00, 32'd3, 32'd4);
    chk("done_start_busy", bus.busy, 1);
    wait_done(0, n, to);
    chk("done_start_timeout", to, 0);
    chk("done_start_latency", 64'(n), 64'(exp_lat(2'b00, 32'd4)));
    chk("done_start_lo", bus.lo_data, 32'd12);
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    chk("no_extra_done", 64'(seen), 0);

    // mthi and start in the same IDLE cycle.
    bus.mthi_we = 1'b1; bus.wdata = 32'h0000_AAAA;
    launch(2'b01, 32'd2, 32'd3);
    bus.mthi_we = 1'b0;
    chk("mt_start_hi_early", bus.hi_data, 32'h0000_AAAA);
    wait_done(0, n, to);
    chk("mt_start_timeout", to, 0);
    chk("mt_start_hi", bus.hi_data, 0);
    chk("mt_start_lo", bus.lo_data, 32'd6);
    @(negedge clk);

    bus.mthi_we = 1'b1; bus.mtlo_we = 1'b1; bus.wdata = 32'h55;
    @(negedge clk);
    bus.mthi_we = 1'b0; bus.mtlo_we = 1'b0;
    chk("both_we_hi", bus.hi_data, 32'h55);
    chk("both_we_lo", bus.lo_data, 32'h55);

    bus.mthi_we = 1'b1; bus.wdata = 32'h11;
    @(negedge clk);
    bus.mthi_we = 1'b0; bus.mtlo_we = 1'b1; bus.wdata = 32'h22;
    @(negedge clk);
    bus.mtlo_we = 1'b0;
    chk("preset_hi", bus.hi_data, 32'h11);
    chk("preset_lo", bus.lo_data, 32'h22);

    for (int k = 0; k < 2; k++) begin
      launch((k == 0) ? 2'b11 : 2'b10, (k == 0) ? 32'd5 : 32'hFFFF_FFFD, 32'd0);
      wait_done(0, n, to);
      chk($sformatf("dz%0d_timeout", k), to, 0);
      chk($sformatf("dz%0d_latency", k), 64'(n), 2);
      chk($sformatf("dz%0d_flag", k), bus.div_by_zero, 1);
      chk($sformatf("dz%0d_hi", k), bus.hi_data, 32'h11);
      chk($sformatf("dz%0d_lo", k), bus.lo_data, 32'h22);
      @(negedge clk);
      chk($sformatf("dz%0d_flag_clear", k), bus.div_by_zero, 0);
      chk($sformatf("dz%0d_done_clear", k), bus.done, 0);
    end

    // Asynchronous reset mid-CALC aborts without done.
    launch(2'b10, 32'd1000, 32'd3);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_hi", bus.hi_data, 0);
    chk("abort_lo", bus.lo_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen++;
    end
    chk("abort_no_done", 64'(seen), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
